hex_display_scheduler: RTL

HEX_DISPLAY_SCHEDULER -- requirements
Module: hex_display_scheduler

---
 rtl/hex_display_scheduler_if.sv | 21 ++
 rtl/hex_display_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hex_display_scheduler_if.sv
// Requester-side bus of the hex display scheduler: request/data/blink in,
// registered display drive and grant status out.
interface hex_display_scheduler_if;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  blink;
    logic [7:0]  disp_data;
    logic        disp_en;
    logic [3:0]  grant;
    logic        busy;

    modport master (
        output req, data, blink,
        input  disp_data, disp_en, grant, busy
    );

    modport slave (
        input  req, data, blink,
        output disp_data, disp_en, grant, busy
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// Round-robin scheduler sharing one two-digit hex display among four
// requesters, with a minimum dwell per grant and optional blinking.
module hex_display_scheduler #(
    parameter int unsigned DWELL      = 50000000,
    parameter int unsigned BLINK_HALF = 12500000
) (
    input logic                    clk,
    input logic                    rst,
    hex_display_scheduler_if.slave bus
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t        state_r, state_n;
    logic [3:0]    grant_r, grant_n;
    logic [1:0]    last_r, last_n;
    logic [DW-1:0] dwell_r, dwell_n;
    logic [BW-1:0] bcnt_r, bcnt_n;
    logic          phase_r, phase_n;
    logic [7:0]    disp_data_r, disp_data_n;
    logic          disp_en_r, disp_en_n;
    logic          busy_r, busy_n;

    logic [1:0]    win;
    logic          win_ok;
    logic          do_grant;
    logic          bwrap;
    logic [BW-1:0] bcnt_adv;
    logic          phase_adv;

    // Search order starts just after the last grant; last_r resets to 3 so
    // the first grant after reset favours index 0.
    always_comb begin
        win    = last_r;
        win_ok = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (!win_ok && bus.req[last_r + 2'(k)]) begin
                win    = last_r + 2'(k);
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        bwrap     = (bcnt_r == BLINK_LAST);
        bcnt_adv  = bwrap ? '0 : bcnt_r + 1'b1;
        phase_adv = phase_r ^ bwrap;
    end

    // While in SHOW, last_r always holds the index of the current owner.
    always_comb begin
        state_n  = state_r;
        grant_n  = grant_r;
        last_n   = last_r;
        dwell_n  = dwell_r;
        bcnt_n   = bcnt_r;
        phase_n  = phase_r;
        do_grant = 1'b0;

        case (state_r)
            IDLE: begin
                if (win_ok) do_grant = 1'b1;
            end
            SHOW: begin
                if (!bus.req[last_r]) begin
                    if (win_ok) begin
                        do_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        dwell_n = '0;
                        bcnt_n  = '0;
                        phase_n = 1'b0;
                    end
                end else if (dwell_r == DWELL_LAST) begin
                    if (|(bus.req & ~grant_r)) begin
                        do_grant = 1'b1;
                    end else begin
                        dwell_n = '0;
                        bcnt_n  = bcnt_adv;
                        phase_n = phase_adv;
                    end
                end else begin
                    dwell_n = dwell_r + 1'b1;
                    bcnt_n  = bcnt_adv;
                    phase_n = phase_adv;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_grant) begin
            state_n = SHOW;
            grant_n = 4'b0001 << win;
            last_n  = win;
            dwell_n = '0;
            bcnt_n  = '0;
            phase_n = 1'b0;
        end

        // Outputs are registered from the next-state view so a new grant
        // shows its byte immediately after the granting edge.
        disp_data_n = 8'h00;
        disp_en_n   = 1'b0;
        busy_n      = 1'b0;
        if (state_n == SHOW) begin
            disp_data_n = 8'(bus.data >> {last_n, 3'b000});
            disp_en_n   = bus.blink[last_n] ? ~phase_n : 1'b1;
            busy_n      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            last_r      <= 2'd3;
            dwell_r     <= '0;
            bcnt_r      <= '0;
            phase_r     <= 1'b0;
            disp_data_r <= '0;
            disp_en_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            last_r      <= last_n;
            dwell_r     <= dwell_n;
            bcnt_r      <= bcnt_n;
            phase_r     <= phase_n;
            disp_data_r <= disp_data_n;
            disp_en_r   <= disp_en_n;
            busy_r      <= busy_n;
        end
    end

    assign bus.disp_data = disp_data_r;
    assign bus.disp_en   = disp_en_r;
    assign bus.grant     = grant_r;
    assign bus.busy      = busy_r;

endmodule
